// File: rtl/key_debounce_if.sv
// Key debouncer pin bundle: raw button input, cleaned strobes/level and FSM state for observation.
// No valid/ready handshake: key_pulse and key_long are single-cycle strobes that the consumer samples every cycle.
interface key_debounce_if;
  logic       key_raw;
  logic       key_pulse;
  logic       key_long;
  logic       key_level;
  logic [1:0] state_dbg;

  modport master (
    output key_raw,
    input  key_pulse,
    input  key_long,
    input  key_level,
    input  state_dbg
  );

  modport slave (
    input  key_raw,
    output key_pulse,
    output key_long,
    output key_level,
    output state_dbg
  );
endinterface

// File: rtl/key_debounce.sv
// Push-button cleaner: 2-FF synchronizer, press/release debounce FSM, long-press and auto-repeat strobes.
module key_debounce #(
  parameter int unsigned DB_CYCLES     = 1_000_000,
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter bit          REPEAT_EN     = 1'b1,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input logic           sys_clk,
  input logic           rst_n,
  key_debounce_if.slave kif
);

  localparam int unsigned HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int DB_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int HOLD_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);
  localparam logic              REL_LVL   = ACTIVE_LOW;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    PRESSED  = 2'd2,
    REL_DB   = 2'd3
  } state_t;

  state_t             state, state_nx;
  logic               s1, s2;
  logic               p;
  logic [DB_W-1:0]    db_cnt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               first_done;
  logic               db_done;
  logic               hold_tc;
  logic               hold_run;
  logic               pulse_d, long_d, level_d;
  logic               pulse_q, long_q, level_q;

  // Sync FFs reset to the released level so leaving reset never looks like a press edge.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      s1 <= REL_LVL;
      s2 <= REL_LVL;
    end else begin
      s1 <= kif.key_raw;
      s2 <= s1;
    end
  end

  assign p        = s2 ^ ACTIVE_LOW;
  assign db_done  = (db_cnt == DB_LAST);
  assign hold_tc  = (hold_cnt == (first_done ? REP_LAST : LONG_LAST));
  assign hold_run = REPEAT_EN || !first_done;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (p) state_nx = PRESS_DB;
      PRESS_DB: begin
        if (!p)          state_nx = IDLE;
        else if (db_done) state_nx = PRESSED;
      end
      PRESSED:  if (!p) state_nx = REL_DB;
      REL_DB:   begin
        if (p)            state_nx = PRESSED;
        else if (db_done) state_nx = IDLE;
      end
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    pulse_d = (state == PRESS_DB) && p && db_done;
    long_d  = (state == PRESSED) && p && hold_run && hold_tc;
    level_d = (state_nx == PRESSED) || (state_nx == REL_DB);
  end

  // Counters and registered outputs; hold_cnt is untouched in REL_DB so a release bounce resumes it.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      db_cnt     <= '0;
      hold_cnt   <= '0;
      first_done <= 1'b0;
      pulse_q    <= 1'b0;
      long_q     <= 1'b0;
      level_q    <= 1'b0;
    end else begin
      pulse_q <= pulse_d;
      long_q  <= long_d;
      level_q <= level_d;
      case (state)
        IDLE: if (p) db_cnt <= '0;
        PRESS_DB: begin
          if (p) begin
            if (db_done) begin
              hold_cnt   <= '0;
              first_done <= 1'b0;
            end else begin
              db_cnt <= db_cnt + 1'b1;
            end
          end
        end
        PRESSED: begin
          if (!p) begin
            db_cnt <= '0;
          end else if (hold_run) begin
            if (hold_tc) begin
              hold_cnt   <= '0;
              first_done <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        REL_DB: if (!p && !db_done) db_cnt <= db_cnt + 1'b1;
        default: db_cnt <= '0;
      endcase
    end
  end

  assign kif.key_pulse = pulse_q;
  assign kif.key_long  = long_q;
  assign kif.key_level = level_q;
  assign kif.state_dbg = state;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with short timing parameters; two instances differ only in REPEAT_EN.
module tb_key_debounce;
  localparam int unsigned DB   = 4;
  localparam int unsigned LONG = 20;
  localparam int unsigned REP  = 5;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  logic key_raw = 1'b1;

  int n_assert  = 0;
  int n_fail    = 0;
  int pulse_cnt = 0;
  int long_cnt0 = 0;
  int long_cnt1 = 0;

  key_debounce_if if0 ();
  key_debounce_if if1 ();

  assign if0.key_raw = key_raw;
  assign if1.key_raw = key_raw;

  key_debounce #(
    .DB_CYCLES(DB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .REPEAT_EN(1'b1), .ACTIVE_LOW(1'b1)
  ) u_dut (
    .sys_clk(sys_clk),
    .rst_n  (rst_n),
    .kif    (if0.slave)
  );

  key_debounce #(
    .DB_CYCLES(DB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .REPEAT_EN(1'b0), .ACTIVE_LOW(1'b1)
  ) u_norep (
    .sys_clk(sys_clk),
    .rst_n  (rst_n),
    .kif    (if1.slave)
  );

  // Clock / reset
  always #5 sys_clk = ~sys_clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge sys_clk);
  endtask

  task automatic chk(input string tag, input logic act, input logic exp);
    n_assert++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", tag, act, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int act, input int exp);
    n_assert++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [1:0] exp);
    n_assert++;
    assert (if0.state_dbg === exp) else begin
      n_fail++;
      $error("FAIL %s: got state %0d expected %0d", tag, if0.state_dbg, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_pulse"}, if0.key_pulse, 1'b0);
    chk({tag, "_long"},  if0.key_long,  1'b0);
    chk({tag, "_level"}, if0.key_level, 1'b0);
  endtask

  // Clean press held p_ticks edges (edge 0 = first edge sampling the press), then released.
  // PRESSED entered at edge DB+2=6 -> outputs at tick 7; first long after 20 held cycles (tick 27),
  // repeats every 5; last held edge is p_ticks+1; release accepted at edge p_ticks+6.
  task automatic press_run(input string tag, input int p_ticks, input int total);
    key_raw = 1'b0;
    for (int t = 1; t <= total; t++) begin
      tick();
      chk({tag, "_pulse"}, if0.key_pulse, t == 7);
      chk({tag, "_level"}, if0.key_level, (t >= 7) && (t < p_ticks + 7));
      chk({tag, "_long"},  if0.key_long,  (t >= 27) && ((t - 27) % 5 == 0) && (t <= p_ticks + 2));
      chk({tag, "_long_norep"}, if1.key_long, (t == 27) && (t <= p_ticks + 2));
      chk({tag, "_excl"}, if0.key_pulse & if0.key_long, 1'b0);
      if (if0.key_pulse === 1'b1) pulse_cnt++;
      if (if0.key_long === 1'b1)  long_cnt0++;
      if (if1.key_long === 1'b1)  long_cnt1++;
      if (t == p_ticks) key_raw = 1'b1;
    end
  endtask

  initial begin
    // Reset with key released
    rst_n   = 1'b0;
    key_raw = 1'b1;
    repeat (3) tick();
    chk_quiet("reset");
    chk_state("reset_state", 2'd0);
    rst_n = 1'b1;
    repeat (2) tick();
    chk_quiet("post_reset");

    // 1: clean press held 40 cycles, then release (includes a repeat strobe on the last held edge)
    press_run("clean", 40, 50);
    chk_state("clean_idle", 2'd0);

    // 2: press bounce, toggling every 2 cycles never reaches DB stable samples
    for (int k = 0; k < 20; k++) begin
      key_raw = ((k / 2) % 2) != 0;
      tick();
      chk_quiet("pbounce");
    end
    key_raw = 1'b1;
    repeat (6) tick();
    chk_state("pbounce_idle", 2'd0);
    chk_quiet("pbounce_end");

    // 3: accepted press, then single-cycle release glitches 1,0,1,0 then steady released
    key_raw = 1'b0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      chk("rb_press_pulse", if0.key_pulse, t == 7);
      chk("rb_press_level", if0.key_level, t >= 7);
    end
    for (int j = 1; j <= 14; j++) begin
      key_raw = !((j == 2) || (j == 4));
      tick();
      chk("rb_pulse", if0.key_pulse, 1'b0);
      chk("rb_long",  if0.key_long,  1'b0);
      chk("rb_level", if0.key_level, j <= 10);
    end
    chk_state("rb_idle", 2'd0);

    // 4: long hold, 60 held cycles in PRESSED -> 9 repeating strobes, 1 without repeat
    long_cnt0 = 0;
    long_cnt1 = 0;
    press_run("hold", 65, 75);
    chk_int("hold_long_count", long_cnt0, 9);
    chk_int("hold_long_count_norep", long_cnt1, 1);
    chk_state("hold_idle", 2'd0);

    // 5: reset while PRESSED with key held; released during reset, no strobe until re-press
    key_raw = 1'b0;
    repeat (10) tick();
    chk("mid_level", if0.key_level, 1'b1);
    chk_state("mid_state", 2'd2);
    rst_n = 1'b0;
    tick();
    chk_quiet("mid_reset");
    chk_state("mid_reset_state", 2'd0);
    key_raw = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int t = 0; t < 12; t++) begin
      tick();
      chk_quiet("mid_after");
    end
    pulse_cnt = 0;
    press_run("repress", 12, 20);
    chk_int("repress_pulse_count", pulse_cnt, 1);

    // 6: back-to-back presses separated by 6 released cycles
    pulse_cnt = 0;
    press_run("b2b_a", 10, 16);
    press_run("b2b_b", 10, 20);
    chk_int("b2b_pulse_count", pulse_cnt, 2);
    chk_state("b2b_idle", 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
